// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with bus parking, locked
// sequences that are never split, and a bounded per-master tenure.
//
// Ports:
//   HCLK, HRESETn  clock and asynchronous active-low reset
//   HBUSREQ        per-master bus request
//   HLOCK          per-master locked-transfer request
//   HTRANS         transfer type of the current owner (IDLE/BUSY/NSEQ/SEQ)
//   HBURST         burst type of the current owner (0 = single)
//   HREADY         slave-side ready
//   HGRANT         one-hot grant (registered)
//   HMASTER        address-phase owner index (registered)
//   HMASTLOCK      address phase is locked (registered)
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int TW =
    (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [TW-1:0] TMAX = TW'(MAX_TENURE);

  typedef enum logic [1:0] {
    S_PARK,
    S_OWNED,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_owner;
  logic [MW-1:0]          r_ptr;
  logic [MW-1:0]          r_master;
  logic                   r_mastlock;
  logic [TW-1:0]          r_tenure;

  logic                   w_busy;
  logic                   w_nseq;
  logic                   w_seq;
  logic                   w_idle;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_others;
  logic                   w_tenure_exp;
  logic                   w_ap;
  logic                   w_found;
  logic [MW-1:0]          w_win;
  logic [MW-1:0]          w_j;
  logic                   w_win_lock;
  logic [MW-1:0]          w_nxt_owner;
  logic [NUM_MASTERS-1:0] w_nxt_grant;
  logic                   w_gchange;
  logic [TW-1:0]          w_tenure_nxt;

  // Any encoding other than BUSY/NSEQ/SEQ (including X) reads as IDLE.
  always_comb begin
    w_busy = 1'b0;
    w_nseq = 1'b0;
    w_seq  = 1'b0;
    case (HTRANS)
      2'b01:   w_busy = 1'b1;
      2'b10:   w_nseq = 1'b1;
      2'b11:   w_seq  = 1'b1;
      default: ;
    endcase
  end

  assign w_idle     = !(w_busy || w_nseq || w_seq);
  assign w_own_req  = HBUSREQ[r_owner];
  assign w_own_lock = HLOCK[r_owner];
  assign w_others   = |(HBUSREQ & ~r_grant);

  assign w_tenure_exp =
    (MAX_TENURE != 0) && (r_tenure >= TMAX);

  // A locked owner releasing HLOCK makes that edge an
  // arbitration point regardless of the transfer type.
  always_comb begin
    w_ap = 1'b0;
    if (HREADY) begin
      if (r_state == S_LOCKED) begin
        w_ap = !w_own_lock;
      end else begin
        w_ap = w_idle
            || (w_nseq && (HBURST == 3'd0))
            || (!w_own_req && !w_seq && !w_busy)
            || w_tenure_exp;
      end
    end
  end

  // Round-robin search from ptr+1; the owner is skipped in
  // the sweep and only considered once everyone else is idle.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_owner;
    w_j     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_j = MW'((int'(r_ptr) + i) % NUM_MASTERS);
      if (!w_found && HBUSREQ[w_j] && (w_j != r_owner)) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
    if (!w_found && w_own_req) begin
      w_found = 1'b1;
      w_win   = r_owner;
    end
  end

  assign w_win_lock = HLOCK[w_win];

  always_comb begin
    w_nxt_owner = r_owner;
    if (w_ap) begin
      w_nxt_owner = w_found ? w_win : DEF_IDX;
    end
    w_nxt_grant = '0;
    w_nxt_grant[w_nxt_owner] = 1'b1;
  end

  assign w_gchange = (w_nxt_owner != r_owner);

  always_comb begin
    w_tenure_nxt = r_tenure;
    if (w_gchange) begin
      w_tenure_nxt = '0;
    end else if (HREADY && w_others && (r_tenure < TMAX)) begin
      w_tenure_nxt = r_tenure + TW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_PARK;
      r_grant    <= DEF_GRANT;
      r_owner    <= DEF_IDX;
      r_ptr      <= DEF_IDX;
      r_master   <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_tenure   <= '0;
    end else begin
      r_tenure <= w_tenure_nxt;
      r_grant  <= w_nxt_grant;
      r_owner  <= w_nxt_owner;
      // Address phase follows the grant on HREADY edges only.
      if (HREADY) begin
        r_master   <= r_owner;
        r_mastlock <= w_own_lock;
      end
      if (w_ap) begin
        if (w_found) begin
          r_ptr <= w_win;
          // A lock raised on an AP only sticks if the
          // locking owner also wins that AP.
          if ((w_win == r_owner) && w_win_lock) begin
            r_state <= S_LOCKED;
          end else begin
            r_state <= S_OWNED;
          end
        end else begin
          r_state <= S_PARK;
        end
      end else if (HREADY && (r_state != S_LOCKED)
                   && w_own_lock) begin
        r_state <= S_LOCKED;
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares one AHB address/data bus between NUM_MASTERS requesters (AHP_master instances plus a default/parking master).
- Samples each master's bus request and lock, then issues a one-hot HGRANT using round-robin priority.
- Drives HMASTER and HMASTLOCK for the slave-side mux and decoder.
- Never splits a locked sequence. Bounds how long one master can hold the bus.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- DEFAULT_MASTER, 0, index granted when nobody requests (bus parking).
- MAX_TENURE, 16, max HREADY-qualified cycles a master keeps the grant while others wait; 0 disables the limit.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  muxed transfer type of the current owner (0 IDLE, 1 BUSY, 2 NON_SEQ, 3 SEQ).
- HBURST  in  3  muxed burst type of the current owner; 0 means single.
- HREADY  in  1  bus ready from the slave side.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  clog2(NUM_MASTERS)  index of the master owning the address phase, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Reset (async, HRESETn low):
  - HGRANT = one-hot(DEFAULT_MASTER).
  - HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - Tenure counter = 0.
  - Round-robin pointer = DEFAULT_MASTER.
  - Reset mid-transfer takes effect immediately; no burst completion.
- FSM has three states:
  - PARK: DEFAULT_MASTER granted, no request pending.
  - OWNED: a requesting master holds the grant.
  - LOCKED: the owner asserts HLOCK.
- Arbitration point (AP): a rising HCLK edge where all of the following hold:
  - HREADY = 1.
  - State != LOCKED.
  - One of these is true:
    - HTRANS = IDLE;
    - HTRANS = NON_SEQ with HBURST = 0;
    - HBUSREQ[owner] = 0 and HTRANS != SEQ/BUSY;
    - tenure counter >= MAX_TENURE (MAX_TENURE != 0).
- Outside an AP, HGRANT holds. SEQ and BUSY beats are never interrupted except by tenure expiry.
- Winner selection at an AP:
  - Search HBUSREQ starting at (pointer+1) mod NUM_MASTERS, wrapping.
  - The first set bit wins, and the pointer moves to the winner.
  - The owner is considered last, so it keeps the bus only if no other master requests.
  - If no bit is set, grant DEFAULT_MASTER and go to PARK.
- HGRANT changes at the AP edge itself (0 cycles after the decision).
- Address-phase handover: HMASTER <= index(HGRANT) on the first edge where HREADY = 1, at or after the grant change. HREADY low stalls the handover indefinitely.
- HMASTLOCK <= HLOCK[index(HGRANT)] on the same HREADY-qualified edge as HMASTER.
- LOCKED state:
  - Entered at the handover edge when HLOCK of the new owner = 1.
  - Also entered from OWNED when HLOCK[owner] rises while HREADY = 1.
  - Left when HLOCK[owner] = 0 and HREADY = 1; that same edge is an AP.
  - The tenure limit is ignored while LOCKED.
- Tenure counter:
  - Cleared on every grant change.
  - Increments on HREADY = 1 edges while another master's HBUSREQ is set.
  - Saturates at MAX_TENURE.
- Simultaneous events:
  - Request and release on the same edge: arbitration uses that edge's sampled HBUSREQ.
  - An HLOCK rise coinciding with an AP: lock wins only if the locking master is the arbitration winner.
- HGRANT is always exactly one-hot. X/invalid HTRANS is treated as IDLE.

Test Plan:
- Reset then idle: HBUSREQ=0 for 10 cycles -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0.
- Single transfers with HBUSREQ=4'b0110 held, HTRANS=NON_SEQ, HBURST=0, HREADY=1:
  - HGRANT sequence 0010, 0100, 0010, 0100 (round-robin).
  - HMASTER follows one cycle later: 1, 2, 1, 2.
- Burst protection: master 1 owns with HTRANS=NON_SEQ, HBURST=3, then SEQ x3 and BUSY x1; master 3 requests meanwhile -> HGRANT stays 0010 until HTRANS=IDLE, then 1000 on that edge.
- Handover stall: grant to master 2 while HREADY=0 for 3 cycles -> HMASTER keeps the old value; HMASTER=2 on the first HREADY=1 edge.
- Lock: master 1 raises HLOCK with an 8-beat SEQ stream, MAX_TENURE=4, master 2 requesting -> HMASTLOCK=1 and no grant change for all 8 beats. After HLOCK=0 and HTRANS=IDLE, HGRANT=0100.
- Tenure and reset: master 0 runs unlocked SEQ for 20 beats with master 3 requesting, MAX_TENURE=16 -> HGRANT=1000 after 16 HREADY cycles. HRESETn pulsed low mid-burst -> HGRANT=0001 and HMASTER=0 immediately.
